// File: rtl/oled_pkg.sv
// Shared geometry, blank code and state encoding for the OLED text scheduler.
package oled_pkg;
  localparam int          ROWS       = 4;
  localparam int          COLS       = 16;
  localparam int          CELLS      = ROWS * COLS;
  localparam int          AW         = 6;
  localparam int          CW         = 7;
  localparam logic [CW-1:0] BLANK_CHAR = 7'h20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } state_e;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/oled_text_sched_text_buf_ram.sv
// 64x7 text buffer: one write port, registered read port. The array itself has no reset.
module text_buf_ram
  import oled_pkg::*;
#(
  parameter int DEPTH = CELLS
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  wr_req_t       wr,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data
);
  logic [CW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  // A same-edge write to rd_addr is not visible here: the old contents are captured.
  always_ff @(posedge i_clk) begin
    if (i_rst)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/oled_text_sched.sv
// Replays the 4x16 text buffer into oled_cntrl's char handshake; owns clears and frame scheduling.
module oled_text_sched
  import oled_pkg::state_e, oled_pkg::wr_req_t,
         oled_pkg::IDLE, oled_pkg::CLEAR, oled_pkg::FETCH, oled_pkg::SEND, oled_pkg::GAP;
#(
  parameter int         ROWS         = oled_pkg::ROWS,
  parameter int         COLS         = oled_pkg::COLS,
  parameter logic [6:0] BLANK_CHAR   = oled_pkg::BLANK_CHAR,
  parameter bit         AUTO_REFRESH = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [5:0] i_wr_addr,
  input  logic [6:0] i_wr_char,
  input  logic       i_refresh,
  input  logic       i_clear,
  output logic [6:0] o_char,
  output logic       o_char_valid,
  input  logic       i_char_done,
  output logic       o_busy,
  output logic       o_clearing,
  output logic       o_frame_done
);
  localparam int         CELLS = ROWS * COLS;
  localparam logic [5:0] LAST  = 6'(CELLS - 1);

  state_e     state;
  logic [5:0] rd_ptr, clr_ptr;
  logic       pend_refresh, pend_clear;
  logic       wr_ok, launch;
  wr_req_t    ram_wr;

  assign wr_ok  = i_wr_en && (state != CLEAR) && (int'(i_wr_addr) < CELLS);
  assign launch = (state == IDLE) && !pend_clear && pend_refresh;

  // Clear sweep owns the write port; host writes are dropped meanwhile.
  always_comb begin
    ram_wr = '0;
    if (state == CLEAR) ram_wr = '{en: 1'b1, addr: clr_ptr, data: BLANK_CHAR};
    else if (wr_ok)     ram_wr = '{en: 1'b1, addr: i_wr_addr, data: i_wr_char};
  end

  text_buf_ram #(.DEPTH(CELLS)) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr      (ram_wr),
    .rd_en   (state == FETCH),
    .rd_addr (rd_ptr),
    .rd_data (o_char)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      clr_ptr      <= '0;
      pend_refresh <= 1'b1;
      pend_clear   <= 1'b1;
      o_char_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_clearing   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_clear) begin
            state      <= CLEAR;
            o_busy     <= 1'b1;
            o_clearing <= 1'b1;
          end else if (pend_refresh) begin
            state        <= FETCH;
            rd_ptr       <= '0;
            pend_refresh <= 1'b0;
            o_busy       <= 1'b1;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 6'd1;
          if (clr_ptr == LAST) begin
            clr_ptr      <= '0;
            pend_clear   <= 1'b0;
            pend_refresh <= 1'b1;
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_clearing   <= 1'b0;
          end
        end
        FETCH: begin
          state        <= SEND;
          o_char_valid <= 1'b1;
        end
        SEND: begin
          if (i_char_done) begin
            o_char_valid <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: begin
          if (rd_ptr == LAST) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end else begin
            rd_ptr <= rd_ptr + 6'd1;
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      if (i_clear) pend_clear <= 1'b1;
      // A write landing on the launch edge is already visible to the frame being started.
      if (i_refresh || (AUTO_REFRESH && wr_ok && !launch)) pend_refresh <= 1'b1;
    end
  end
endmodule

// File: tb/tb_oled_text_sched.sv
// Directed bench for oled_text_sched: scoreboarded glyph stream against a bench-side buffer model.
module tb_oled_text_sched;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [5:0] i_wr_addr = '0;
  logic [6:0] i_wr_char = '0;
  logic       i_refresh = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_char_done = 1'b0;
  logic [6:0] o_char;
  logic       o_char_valid, o_busy, o_clearing, o_frame_done;

  int nvec = 0, nerr = 0;
  logic [6:0] expq[$];
  logic [6:0] mdl[64];
  int glyphs = 0, frames = 0, clears = 0, clr_len = 0;
  bit hold_done = 1'b0;
  bit pv = 1'b0;
  logic [6:0] pc = '0;
  int vcnt = 0;
  bit dd = 1'b0;

  always #5 i_clk = ~i_clk;

  oled_text_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_char(i_wr_char), .i_refresh(i_refresh), .i_clear(i_clear),
    .o_char(o_char), .o_char_valid(o_char_valid), .i_char_done(i_char_done),
    .o_busy(o_busy), .o_clearing(o_clearing), .o_frame_done(o_frame_done)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each new glyph, checks stability and frame/clear lengths.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pv = 1'b0;
        clr_len = 0;
      end else begin
        if (o_char_valid && !pv) begin
          if (expq.size() == 0) chk("unexpected_glyph", 32'(glyphs), 32'hFFFF);
          else chk($sformatf("glyph%0d", glyphs), 32'(o_char), 32'(expq.pop_front()));
          glyphs++;
        end
        if (o_char_valid && pv) chk("char_stable", 32'(o_char), 32'(pc));
        if (o_frame_done) begin
          chk("glyphs_per_frame", 32'(glyphs), 32'd64);
          glyphs = 0;
          frames++;
        end
        if (o_clearing) begin
          clr_len++;
          chk("busy_in_clear", 32'(o_busy), 32'd1);
        end else if (clr_len != 0) begin
          chk("clear_len", 32'(clr_len), 32'd64);
          clr_len = 0;
          clears++;
        end
        pv = o_char_valid;
        pc = o_char;
      end
    end
  end

  // Downstream model: done pulses two cycles into each valid; valid must drop right after done.
  initial begin
    forever begin
      @(negedge i_clk);
      if (dd) chk("gap_after_done", 32'(o_char_valid), 32'd0);
      i_char_done = 1'b0;
      dd = 1'b0;
      if (o_char_valid === 1'b1 && !hold_done) begin
        vcnt++;
        if (vcnt >= 2) begin
          i_char_done = 1'b1;
          dd = 1'b1;
          vcnt = 0;
        end
      end else if (o_char_valid !== 1'b1) begin
        vcnt = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 64; i++) expq.push_back(mdl[i]);
  endtask

  task automatic host_wr(logic [5:0] a, logic [6:0] c);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_char = c;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic pulse(bit rf, bit cl);
    i_refresh = rf; i_clear = cl;
    @(negedge i_clk);
    i_refresh = 1'b0; i_clear = 1'b0;
  endtask

  task automatic wait_frames(int target, string tag);
    int budget = 4000;
    while (frames < target && budget > 0) begin @(negedge i_clk); budget--; end
    chk(tag, 32'(frames), 32'(target));
  endtask

  task automatic wait_glyph(int n, string tag);
    int budget = 2000;
    while (glyphs < n && budget > 0) begin @(negedge i_clk); budget--; end
    chk(tag, 32'(glyphs), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 7'h20;

    // Reset state, then power-up clear plus one blank frame.
    cyc(3);
    chk("rst_char", 32'(o_char), 32'd0);
    chk("rst_valid", 32'(o_char_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_clearing", 32'(o_clearing), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    push_frame();
    i_rst = 1'b0;
    wait_frames(1, "t1_frame");
    cyc(2);
    chk("t1_idle", 32'(o_busy), 32'd0);
    chk("t1_clears", 32'(clears), 32'd1);
    chk("t1_q_empty", 32'(expq.size()), 32'd0);
    cyc(300);
    chk("t1_no_extra", 32'(frames), 32'd1);

    // Two idle writes schedule a single frame.
    mdl[0] = 7'h48; mdl[17] = 7'h49;
    push_frame();
    host_wr(6'd0, 7'h48);
    host_wr(6'd17, 7'h49);
    wait_frames(2, "t2_frame");
    cyc(300);
    chk("t2_no_extra", 32'(frames), 32'd2);

    // Writes mid-frame: unsent cell appears now, sent cell in the following frame.
    mdl[40] = 7'h42;
    push_frame();
    pulse(1'b1, 1'b0);
    wait_glyph(11, "t3_reach_cell10");
    host_wr(6'd5, 7'h41);
    host_wr(6'd40, 7'h42);
    mdl[5] = 7'h41;
    push_frame();
    wait_frames(4, "t3_two_frames");
    cyc(300);
    chk("t3_no_extra", 32'(frames), 32'd4);

    // Stalled downstream: valid and char held for 1000 cycles.
    hold_done = 1'b1;
    push_frame();
    pulse(1'b1, 1'b0);
    wait_glyph(1, "t4_first_glyph");
    cyc(1000);
    chk("t4_valid_held", 32'(o_char_valid), 32'd1);
    chk("t4_char_held", 32'(o_char), 32'h48);
    hold_done = 1'b0;
    wait_frames(5, "t4_frame");
    cyc(20);

    // Clear+refresh mid-frame: frame finishes, clear, one blank frame; writes in clear dropped.
    push_frame();
    pulse(1'b1, 1'b0);
    wait_glyph(21, "t5_reach_cell20");
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 64; i++) mdl[i] = 7'h20;
    push_frame();
    begin
      int budget = 1000;
      while (o_clearing !== 1'b1 && budget > 0) begin @(negedge i_clk); budget--; end
      chk("t5_clear_start", 32'(o_clearing), 32'd1);
    end
    cyc(10);
    host_wr(6'd3, 7'h55);
    wait_frames(7, "t5_frames");
    cyc(300);
    chk("t5_no_extra", 32'(frames), 32'd7);
    chk("t5_clears", 32'(clears), 32'd2);

    // Reset mid-frame at cell 30: abort, then full clear and frame from cell 0.
    push_frame();
    pulse(1'b1, 1'b0);
    wait_glyph(31, "t6_reach_cell30");
    i_rst = 1'b1;
    expq.delete();
    glyphs = 0;
    cyc(1);
    chk("t6_valid_drop", 32'(o_char_valid), 32'd0);
    chk("t6_busy_drop", 32'(o_busy), 32'd0);
    cyc(2);
    push_frame();
    i_rst = 1'b0;
    wait_frames(8, "t6_frame");
    cyc(2);
    chk("t6_clears", 32'(clears), 32'd3);
    chk("t6_q_empty", 32'(expq.size()), 32'd0);
    chk("t6_idle", 32'(o_busy), 32'd0);

    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
